// File: rtl/serv_seq_pkg.sv
// Shared types and constants for the bit-serial execution sequencer.
// Stage length and counter wrap point depend on the datapath width W.
package serv_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_INIT   = 3'd3,
        S_WAIT   = 3'd4,
        S_RUN    = 3'd5
    } state_t;

    localparam int CNT_SPAN = 32;

    function automatic int stage_len(input int w);
        return CNT_SPAN / w;
    endfunction

    function automatic logic [4:0] cnt_last(input int w);
        return 5'(CNT_SPAN - w);
    endfunction

endpackage

// File: rtl/serv_seq_cnt.sv
// Bit counter shared by every serial unit: steps by W while enabled,
// flags the last slice of a stage and wraps to zero on that edge.
module serv_seq_cnt
    import serv_seq_pkg::*;
#(
    parameter int W = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [4:0] cnt,
    output logic       done
);

    localparam logic [4:0] LAST = cnt_last(W);
    localparam logic [4:0] STEP = 5'(W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 5'd0;
        end else if (clr) begin
            cnt <= 5'd0;
        end else if (en) begin
            cnt <= cnt + STEP;
        end
    end

    assign done = en & (cnt == LAST);

endmodule

// File: rtl/serv_exec_seq.sv
// Fetch / init / wait / run sequencer for the bit-serial core.
// Bus request lines are registered and follow the state transitions.
module serv_exec_seq
    import serv_seq_pkg::*;
#(
    parameter int W = 1
) (
    input  logic       clk,
    input  logic       i_rst_n,
    output logic       o_ibus_cyc,
    input  logic       i_ibus_ack,
    output logic       o_wb_en,
    input  logic       i_two_stage_op,
    input  logic       i_dbus_en,
    input  logic       i_mdu_op,
    input  logic       i_rd_op,
    output logic       o_dbus_cyc,
    input  logic       i_dbus_ack,
    output logic       o_mdu_valid,
    input  logic       i_mdu_ready,
    output logic       o_init,
    output logic       o_cnt_en,
    output logic [4:0] o_cnt,
    output logic       o_cnt_done,
    output logic       o_pc_en,
    output logic       o_rf_wen
);

    state_t state;
    state_t state_n;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   state_n = S_FETCH;
            S_FETCH:  if (o_ibus_cyc & i_ibus_ack) state_n = S_DECODE;
            S_DECODE: state_n = i_two_stage_op ? S_INIT : S_RUN;
            S_INIT:
                if (o_cnt_done)
                    state_n = (i_dbus_en | i_mdu_op) ? S_WAIT : S_RUN;
            S_WAIT:
                if ((o_dbus_cyc & i_dbus_ack) | (o_mdu_valid & i_mdu_ready))
                    state_n = S_RUN;
            S_RUN:    if (o_cnt_done) state_n = S_FETCH;
            default:  state_n = S_IDLE;
        endcase
    end

    // The wait kind is chosen on entry and then held by its own flop.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ibus_cyc  <= 1'b0;
            o_dbus_cyc  <= 1'b0;
            o_mdu_valid <= 1'b0;
        end else begin
            o_ibus_cyc  <= (state_n == S_FETCH);
            o_dbus_cyc  <= (state_n == S_WAIT) &
                           ((state == S_WAIT) ? o_dbus_cyc : i_dbus_en);
            o_mdu_valid <= (state_n == S_WAIT) &
                           ((state == S_WAIT) ? o_mdu_valid : ~i_dbus_en);
        end
    end

    always_comb begin
        o_init   = 1'b0;
        o_cnt_en = 1'b0;
        o_pc_en  = 1'b0;
        o_rf_wen = 1'b0;
        unique case (1'b1)
            (state == S_INIT): begin
                o_init   = 1'b1;
                o_cnt_en = 1'b1;
            end
            (state == S_RUN): begin
                o_cnt_en = 1'b1;
                o_pc_en  = 1'b1;
                o_rf_wen = i_rd_op;
            end
            default: ;
        endcase
    end

    assign o_wb_en = o_ibus_cyc & i_ibus_ack;

    serv_seq_cnt #(.W(W)) u_cnt (
        .clk   (clk),
        .rst_n (i_rst_n),
        .en    (o_cnt_en),
        .clr   (~o_cnt_en),
        .cnt   (o_cnt),
        .done  (o_cnt_done)
    );

endmodule

// File: doc/serv_exec_seq.md
# serv_exec_seq

Execution sequencer for the bit-serial core. It fetches one instruction over the instruction bus and pulses the decoder's latch enable. It then walks the decoded instruction through an optional init stage, an optional external wait (data bus or MDU) and a final run stage, driving the bit counter that every serial datapath unit consumes. It sits between the bus interfaces and the decoder/ALU/bufreg/RF, and consumes the decoder's registered control outputs.

## Interface
- W, default 1: serial datapath width in bits per cycle; legal values 1 and 4. Each stage lasts 32/W cycles.
- clk  in  1  core clock.
- i_rst_n  in  1  reset; asynchronous and active-low.
- o_ibus_cyc  out  1  instruction fetch request; held until acknowledged.
- i_ibus_ack  in  1  fetch acknowledge; instruction data is valid this cycle.
- o_wb_en  out  1  decoder latch enable; equals o_ibus_cyc & i_ibus_ack (combinational).
- i_two_stage_op  in  1  from decoder: instruction needs an init stage.
- i_dbus_en  in  1  from decoder: load/store.
- i_mdu_op  in  1  from decoder: M-extension op.
- i_rd_op  in  1  from decoder: instruction writes rd.
- o_dbus_cyc  out  1  data bus request.
- i_dbus_ack  in  1  data bus acknowledge.
- o_mdu_valid  out  1  MDU start request.
- i_mdu_ready  in  1  MDU result ready.
- o_init  out  1  init stage active.
- o_cnt_en  out  1  serial datapath active (init or run).
- o_cnt  out  5  current bit index of the LSB processed this cycle.
- o_cnt_done  out  1  last cycle of the current stage.
- o_pc_en  out  1  PC update enable; high during run.
- o_rf_wen  out  1  RF write enable; run & i_rd_op.

## Operation
- States: IDLE, FETCH, DECODE, INIT, WAIT, RUN. Encoding is 3-bit binary.
- Reset (async, i_rst_n=0): state IDLE; cnt=0; o_ibus_cyc=0, o_dbus_cyc=0, o_mdu_valid=0. All derived outputs are 0.
- IDLE -> FETCH unconditionally. o_ibus_cyc is set on the same edge.
- FETCH: hold o_ibus_cyc=1. On i_ibus_ack: clear o_ibus_cyc and go to DECODE.
- DECODE: one cycle, so the decoder outputs settle. Then:
  - INIT if i_two_stage_op;
  - otherwise RUN.
- INIT: cnt advances by W each cycle. At o_cnt_done:
  - WAIT if i_dbus_en or i_mdu_op;
  - otherwise RUN.
- WAIT:
  - dbus: o_dbus_cyc is set on entry and held. On i_dbus_ack: clear it and go to RUN.
  - mdu: o_mdu_valid is set on entry and held. On i_mdu_ready: clear it and go to RUN.
  - i_dbus_en has priority if both are set.
- RUN: cnt advances by W. At o_cnt_done: go to FETCH and set o_ibus_cyc.
- Counter rules:
  - 5-bit, step W, zero in all states outside INIT/RUN.
  - o_cnt_done = cnt_en & (cnt == 32-W).
  - Wraps to 0 on the done edge, so INIT -> RUN back-to-back restarts at 0.
- Ignored inputs:
  - i_ibus_ack while o_ibus_cyc=0.
  - i_dbus_ack while o_dbus_cyc=0.
  - i_mdu_ready while o_mdu_valid=0.
- Reset asserted mid-operation aborts any pending bus request immediately. No acknowledge is awaited.

## Timing
- All state, cnt, and bus-request flops are clocked on posedge clk and cleared asynchronously.
- o_wb_en is combinational, with zero latency from i_ibus_ack.
- Single-stage op, W=1, ack at cycle t:
  - DECODE at t+1;
  - RUN t+2..t+33;
  - o_ibus_cyc high again at t+34.
- Two-stage op without wait: INIT t+2..t+33, RUN t+34..t+65.
- Load, W=1, i_dbus_ack at cycle d: RUN starts at d+1. o_dbus_cyc is low from d+1.
- W=4: every stage lasts 8 cycles; o_cnt takes 0,4,...,28.
- Ack in the same cycle the request rises is legal: a 1-cycle handshake.

## Structure
- Package serv_seq_pkg holds:
  - the state encoding constants;
  - the stage-length constant 32/W;
  - the localparam for the done compare value.
- One sub-module: serv_seq_cnt, the 5-bit step-W counter with enable, clear and done output.
- The FSM and bus-request flops stay in serv_exec_seq.

## Test plan
- Reset release, W=1, ibus ack held high: o_ibus_cyc rises on the first edge. o_wb_en pulses once. RUN shows cnt 0..31. o_cnt_done is high only at cnt=31.
- i_two_stage_op=1, i_dbus_en=1, dbus ack delayed 5 cycles: o_init high 32 cycles, then o_dbus_cyc high 5 cycles, then RUN 32 cycles. o_rf_wen follows i_rd_op.
- i_mdu_op=1, i_mdu_ready after 10 cycles: o_mdu_valid high exactly 10 cycles, then RUN. A stray i_dbus_ack during this window is ignored.
- W=4, single-stage op: RUN 8 cycles with o_cnt=0,4,...,28 and done at 28. Next fetch request follows immediately.
- Reset asserted mid-WAIT with o_dbus_cyc=1: o_dbus_cyc=0 and state IDLE without a clock edge. After release, normal fetch resumes.
- Spurious i_ibus_ack during RUN: no o_wb_en, no state change.
